// File: rtl/arbitro_memoria_asteroides.sv
// Round-robin arbiter for the shared asteroid memory: four requesters, one grant at a time,
// released by the winner's done strobe or revoked by a cycle timeout.
module arbitro_memoria_asteroides #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       ocupado_mem,
   output logic       erro_timeout,
   output logic [3:0] cont_timeouts,
   output logic [1:0] db_estado_arbitro
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CONCEDE = 2'd1,
      OCUPADO = 2'd2,
      LIBERA  = 2'd3
   } estado_t;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   estado_t    estado_q, estado_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ultimo_q, ultimo_d;
   logic [7:0] timer_q, timer_d;
   logic       por_timeout_q, por_timeout_d;
   logic [3:0] cont_q, cont_d;

   logic [1:0] vencedor_s;
   logic [1:0] cand_s;
   logic       achou_s;

   // Rotating priority search starting just after the last served requester
   always_comb begin
      vencedor_s = ultimo_q;
      cand_s     = ultimo_q;
      achou_s    = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand_s = ultimo_q + 2'(i);
         if (!achou_s && req[cand_s]) begin
            vencedor_s = cand_s;
            achou_s    = 1'b1;
         end else begin
            achou_s    = achou_s;
         end
      end
   end

   // Next-state logic for the arbitration FSM and its bookkeeping registers
   always_comb begin
      estado_d      = estado_q;
      sel_d         = sel_q;
      ultimo_d      = ultimo_q;
      timer_d       = timer_q;
      por_timeout_d = por_timeout_q;
      cont_d        = cont_q;
      case (estado_q)
         OCIOSO: begin
            if (req != 4'b0000) begin
               sel_d    = vencedor_s;
               estado_d = CONCEDE;
            end else begin
               estado_d = OCIOSO;
            end
         end
         CONCEDE: begin
            timer_d  = 8'd0;
            estado_d = OCUPADO;
         end
         OCUPADO: begin
            // done from the owner wins over a simultaneous timer expiry
            if (done[sel_q]) begin
               estado_d = LIBERA;
            end else if (timer_q == TIMER_LAST) begin
               estado_d      = LIBERA;
               por_timeout_d = 1'b1;
               cont_d        = (cont_q == 4'd15) ? 4'd15 : cont_q + 4'd1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         LIBERA: begin
            ultimo_d      = sel_q;
            por_timeout_d = 1'b0;
            estado_d      = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // State and bookkeeping registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q      <= OCIOSO;
         sel_q         <= 2'd0;
         ultimo_q      <= 2'd3;
         timer_q       <= 8'd0;
         por_timeout_q <= 1'b0;
         cont_q        <= 4'd0;
      end else begin
         estado_q      <= estado_d;
         sel_q         <= sel_d;
         ultimo_q      <= ultimo_d;
         timer_q       <= timer_d;
         por_timeout_q <= por_timeout_d;
         cont_q        <= cont_d;
      end
   end

   // Moore output decode from registered state only
   always_comb begin
      grant        = 4'b0000;
      ocupado_mem  = 1'b0;
      erro_timeout = 1'b0;
      case (estado_q)
         OCIOSO: begin
            ocupado_mem = 1'b0;
         end
         CONCEDE, OCUPADO: begin
            grant       = 4'b0001 << sel_q;
            ocupado_mem = 1'b1;
         end
         LIBERA: begin
            ocupado_mem  = 1'b1;
            erro_timeout = por_timeout_q;
         end
         default: begin
            grant = 4'b0000;
         end
      endcase
   end

   assign sel               = sel_q;
   assign cont_timeouts     = cont_q;
   assign db_estado_arbitro = estado_q;

endmodule

// File: tb/tb_arbitro_memoria_asteroides.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// transaction-level round-robin/timeout model.
module tb_arbitro_memoria_asteroides;

   localparam int TO = 4;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       ocupado_mem;
   logic       erro_timeout;
   logic [3:0] cont_timeouts;
   logic [1:0] db_estado_arbitro;

   int checks   = 0;
   int failures = 0;
   int m_ultimo = 3;
   int m_cont   = 0;

   arbitro_memoria_asteroides #(.TIMEOUT(TO)) dut (
      .clock             (clock),
      .reset             (reset),
      .req               (req),
      .done              (done),
      .grant             (grant),
      .sel               (sel),
      .ocupado_mem       (ocupado_mem),
      .erro_timeout      (erro_timeout),
      .cont_timeouts     (cont_timeouts),
      .db_estado_arbitro (db_estado_arbitro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner = first set bit searching upward from (last+1) mod 4
   function automatic int pick(input logic [3:0] r, input int u);
      for (int i = 1; i <= 4; i++) begin
         if (r[(u + i) % 4]) return (u + i) % 4;
      end
      return -1;
   endfunction

   // One transaction from OCIOSO back to OCIOSO; dly = OCUPADO cycle index of done (>=TO: never)
   task automatic txn(input logic [3:0] rq, input int dly);
      int         w;
      bit         tmo;
      logic [3:0] wb;
      req  = rq;
      done = 4'($urandom);
      w    = pick(rq, m_ultimo);
      @(negedge clock);
      if (w < 0) begin
         chk("idle_state", 8'(db_estado_arbitro), 8'd0);
         chk("idle_grant", 8'(grant), 8'd0);
         chk("idle_ocupado", 8'(ocupado_mem), 8'd0);
         return;
      end
      wb  = 4'(1 << w);
      tmo = (dly >= TO);
      chk("concede_state", 8'(db_estado_arbitro), 8'd1);
      chk("concede_grant", 8'(grant), 8'(wb));
      chk("concede_sel", 8'(sel), 8'(w));
      chk("concede_ocupado", 8'(ocupado_mem), 8'd1);
      req  = 4'($urandom);
      done = 4'($urandom);
      for (int k = 0; k < TO; k++) begin
         @(negedge clock);
         chk("ocupado_state", 8'(db_estado_arbitro), 8'd2);
         chk("ocupado_grant", 8'(grant), 8'(wb));
         chk("ocupado_erro", 8'(erro_timeout), 8'd0);
         req = 4'($urandom);
         if (k == dly) begin
            done = 4'($urandom) | wb;
            break;
         end else begin
            done = 4'($urandom) & ~wb;
         end
      end
      @(negedge clock);
      if (tmo) m_cont = (m_cont >= 15) ? 15 : m_cont + 1;
      chk("libera_state", 8'(db_estado_arbitro), 8'd3);
      chk("libera_grant", 8'(grant), 8'd0);
      chk("libera_ocupado", 8'(ocupado_mem), 8'd1);
      chk("libera_erro", 8'(erro_timeout), 8'(tmo));
      chk("libera_cont", 8'(cont_timeouts), 8'(m_cont));
      req  = 4'b0000;
      done = 4'b0000;
      @(negedge clock);
      chk("ocioso_state", 8'(db_estado_arbitro), 8'd0);
      chk("ocioso_grant", 8'(grant), 8'd0);
      chk("ocioso_erro", 8'(erro_timeout), 8'd0);
      chk("ocioso_cont", 8'(cont_timeouts), 8'(m_cont));
      m_ultimo = w;
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      done  = 4'b0000;
      #1 reset = 1'b0;
      #1;
      chk("rst_state", 8'(db_estado_arbitro), 8'd0);
      chk("rst_grant", 8'(grant), 8'd0);
      chk("rst_sel", 8'(sel), 8'd0);
      chk("rst_ocupado", 8'(ocupado_mem), 8'd0);
      chk("rst_erro", 8'(erro_timeout), 8'd0);
      chk("rst_cont", 8'(cont_timeouts), 8'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      txn(4'b0100, 0);
      repeat (5) txn(4'b1111, 0);
      txn(4'b0010, TO);
      txn(4'b0001, TO - 1);
      txn(4'b0000, 0);
      txn(4'b1000, 1);

      // Reset asserted mid-grant must clear outputs without waiting for a clock
      req = 4'b1000;
      @(negedge clock);
      req = 4'b0000;
      @(negedge clock);
      chk("pre_rst_grant", 8'(grant), 8'b0000_1000);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_grant", 8'(grant), 8'd0);
      chk("async_rst_state", 8'(db_estado_arbitro), 8'd0);
      chk("async_rst_ocupado", 8'(ocupado_mem), 8'd0);
      chk("async_rst_cont", 8'(cont_timeouts), 8'd0);
      @(negedge clock);
      reset    = 1'b1;
      m_ultimo = 3;
      m_cont   = 0;
      txn(4'b1001, 0);

      for (int n = 0; n < 17; n++) txn(4'($urandom) | 4'b0001, TO);
      chk("sat_cont", 8'(cont_timeouts), 8'd15);

      for (int n = 0; n < 60; n++) txn(4'($urandom), int'($urandom_range(0, TO)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
